hex_display_mux: RTL

//  Time-multiplexed N-digit hexadecimal 7-segment display driver for board status readout
//  (flash programmer address/data, debug values). Latches a packed hex word on a load strobe,

---
 rtl/hex_display_mux.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hex_display_mux.sv
// Time-multiplexed N-digit hexadecimal 7-segment driver: latches a hex word on load,
// scans one digit per DIV cycles, and drives shared segments plus one-hot digit enables.
module hex_display_mux #(
    parameter int DIGITS         = 4,
    parameter int DIV            = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [4*DIGITS-1:0] value_reg;
    logic [DIGITS-1:0]   dp_reg;
    logic [6:0]          seg_reg, seg_next;
    logic                dp_out_reg, dp_out_next;
    logic [DIGITS-1:0]   an_reg, an_next;
    logic                frame_reg, frame_next;

    logic                tick;
    logic [DIGITS-1:0]   digit_sel;
    logic [DIGITS-1:0]   lz_dark;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_dark;
    logic [6:0]          seg_on;
    logic                dp_on;
    logic [DIGITS-1:0]   an_on;

    // Segment patterns in active-high gfedcba form.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        unique case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h67;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    // A digit above 0 goes dark when it and every more significant digit carry
    // neither a non-zero nibble nor a decimal point.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_sel[gi] = (idx_reg == IDX_W'(gi));
            if (gi == 0 || !BLANK_LZ) begin : g_no_lz
                assign lz_dark[gi] = 1'b0;
            end else begin : g_lz
                assign lz_dark[gi] = (value_reg[4*DIGITS-1:4*gi] == '0) &&
                                     (dp_reg[DIGITS-1:gi] == '0);
            end
        end
    endgenerate

    always_comb begin
        cur_nib = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_sel[i]) begin
                cur_nib = cur_nib | value_reg[4*i +: 4];
            end
        end
        cur_dp   = |(digit_sel & dp_reg);
        cur_dark = |(digit_sel & lz_dark);

        tick       = (cnt_reg == CNT_LAST);
        cnt_next   = tick ? '0 : cnt_reg + CNT_ONE;
        idx_next   = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_ONE;
        end
        frame_next = tick && (idx_reg == IDX_LAST);

        seg_on = hex_to_seg(cur_nib);
        dp_on  = cur_dp;
        an_on  = digit_sel;
        if (blank) begin
            seg_on = 7'h00;
            dp_on  = 1'b0;
            an_on  = '0;
        end else if (cur_dark) begin
            seg_on = 7'h00;
            dp_on  = 1'b0;
        end

        seg_next    = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
        dp_out_next = SEG_ACTIVE_LOW ? ~dp_on : dp_on;
        an_next     = AN_ACTIVE_LOW ? ~an_on : an_on;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            idx_reg    <= '0;
            value_reg  <= '0;
            dp_reg     <= '0;
            seg_reg    <= SEG_OFF;
            dp_out_reg <= DP_OFF;
            an_reg     <= AN_OFF;
            frame_reg  <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            seg_reg    <= seg_next;
            dp_out_reg <= dp_out_next;
            an_reg     <= an_next;
            frame_reg  <= frame_next;
            if (load) begin
                value_reg <= data;
                dp_reg    <= dp;
            end
        end
    end

    assign seg    = seg_reg;
    assign dp_out = dp_out_reg;
    assign an     = an_reg;
    assign frame  = frame_reg;

endmodule
